// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the tail-lamp sequencer:
//   tl_state_e  - 2-bit FSM state encoding (IDLE, LSEQ, RSEQ, HAZ)
//   phase_w()   - width of the phase counter for N lamps per side. The counter
//                 must hold 0..N, so it needs $clog2(N+1) bits.
// -----------------------------------------------------------------------------
package tl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // all lamps off
    LSEQ = 2'd1,  // left side sequencing
    RSEQ = 2'd2,  // right side sequencing
    HAZ  = 2'd3   // all lamps on
  } tl_state_e;

  // Phase counter width for n lamps per side (n >= 1); never below 1 bit.
  function automatic int phase_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tl_step_tick.sv
// -----------------------------------------------------------------------------
// tl_step_tick
// Clock-enable prescaler. Counts 0..STEP_DIV-1 and wraps; tick is high for the
// single clock in which the count sits at STEP_DIV-1, so STEP_DIV=1 yields a
// tick on every clock.
//
// Parameters:
//   STEP_DIV - clocks per tick (>= 1)
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset; count restarts from 0
//   tick  - one-clock-wide step enable
// -----------------------------------------------------------------------------
module tl_step_tick #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/tail_lamp_sequencer.sv
// -----------------------------------------------------------------------------
// tail_lamp_sequencer
// Sequential tail-lamp controller with N lamps per side. A held turn request
// lights the lamps of that side progressively from the innermost lamp out
// (off, 1, 2, ..., N, off, ...), one step per prescaler tick. Hazard (or left
// and right together) blinks all 2N lamps on/off each tick.
//
// Optional build macro: TL_BRAKE_EN
//   When defined, a brake input is added. While brake is high, every side that
//   is not currently sequencing is forced fully lit. brake is sampled on every
//   clock, not only on ticks.
//
// Parameters:
//   LAMPS_PER_SIDE - lamps per side N (>= 1); bit 0 is the innermost lamp
//   STEP_DIV       - clocks per sequence step (>= 1)
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   left   - left turn request (level)
//   right  - right turn request (level)
//   hazard - hazard request (level)
//   brake  - brake request (level, TL_BRAKE_EN builds only)
//   lamp_l - left lamps, 1 = lit (registered)
//   lamp_r - right lamps, 1 = lit (registered)
// -----------------------------------------------------------------------------
module tail_lamp_sequencer #(
  parameter int LAMPS_PER_SIDE = 3,
  parameter int STEP_DIV       = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      left,
  input  logic                      right,
  input  logic                      hazard,
`ifdef TL_BRAKE_EN
  input  logic                      brake,
`endif
  output logic [LAMPS_PER_SIDE-1:0] lamp_l,
  output logic [LAMPS_PER_SIDE-1:0] lamp_r
);

  import tl_pkg::*;

  localparam int N  = LAMPS_PER_SIDE;
  localparam int PW = phase_w(N);

  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [PW-1:0] PH_LAST = PW'(N);

  tl_state_e       state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [N-1:0]    lamp_l_d, lamp_r_d;
  logic            tick;
  logic            haz_req;

  // Lowest 'ph' bits set: phase k lights lamps 0..k-1.
  function automatic logic [N-1:0] therm(input logic [PW-1:0] ph);
    logic [N-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(ph)) t[i] = 1'b1;
    end
    return t;
  endfunction

  tl_step_tick #(
    .STEP_DIV (STEP_DIV)
  ) u_step_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Both turn stalks at once is indistinguishable from a hazard request.
  assign haz_req = hazard | (left & right);

  // Next-state decode: requests only matter on tick clocks; otherwise hold.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (haz_req) begin
            state_d = HAZ;
            phase_d = '0;
          end else if (left) begin
            state_d = LSEQ;
            phase_d = PH_ONE;
          end else if (right) begin
            state_d = RSEQ;
            phase_d = PH_ONE;
          end
        end
        LSEQ, RSEQ: begin
          // Releasing or swapping the stalk does not abort: the sequence
          // runs out to all-off and the new side starts from IDLE.
          if (haz_req) begin
            state_d = HAZ;
            phase_d = '0;
          end else if (phase_q == PH_LAST) begin
            state_d = IDLE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_ONE;
          end
        end
        HAZ: begin
          // Unconditional return gives the on/off blink of a held hazard.
          state_d = IDLE;
          phase_d = '0;
        end
        default: begin
          state_d = IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so lamps change on the tick edge itself.
  always_comb begin
    lamp_l_d = '0;
    lamp_r_d = '0;
    case (state_d)
      LSEQ:    lamp_l_d = therm(phase_d);
      RSEQ:    lamp_r_d = therm(phase_d);
      HAZ: begin
        lamp_l_d = '1;
        lamp_r_d = '1;
      end
      default: ;
    endcase
`ifdef TL_BRAKE_EN
    // Brake lights every side that is not carrying the turn sequence.
    if (brake) begin
      if (state_d != LSEQ) lamp_l_d = '1;
      if (state_d != RSEQ) lamp_r_d = '1;
    end
`endif
  end

  // State, phase and lamp registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      lamp_l  <= '0;
      lamp_r  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      lamp_l  <= lamp_l_d;
      lamp_r  <= lamp_r_d;
    end
  end

endmodule
